ps2_rx_ctrl: RTL
================

// Module: ps2_rx_ctrl
// PURPOSE
//  Frame sequencer for the PS/2 keyboard port; sits directly after the 2-channel debouncer.
//  Takes the debounced keyboard clock/data, tracks the 11-bit PS/2 frame and assembles the
//  8-bit scan code. Reports frame/parity errors and recovers from stalled frames by timeout.
//  Downstream key-handling logic consumes the single-cycle code_valid strobe.
// PARAMETERS
//  TIMEOUT_CYCLES  100000  clk cycles with no kbd-clock falling edge mid-frame before abort (1 ms @ 100 MHz)
//  TO_W            17      width of timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk            in   1  system clock; everything on posedge
//  rst_n          in   1  asynchronous, active-low reset
//  ps2_clk_db     in   1  debounced keyboard clock (debouncer output)
//  ps2_data_db    in   1  debounced keyboard data (debouncer output)
//  code           out  8  last accepted scan code
//  code_valid     out  1  1-cycle strobe: code updated
//  parity_err     out  1  1-cycle strobe: odd-parity check failed
//  frame_err      out  1  1-cycle strobe: bad stop bit or timeout
//  busy           out  1  high while FSM is not in IDLE
//  release_flag   out  1  valid with code_valid: break (F0) prefix preceded code
//  extended_flag  out  1  valid with code_valid: E0 prefix preceded code
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM=IDLE, code=8'h00, all strobes/flags/busy=0, clk_prev=1,
//   bit_cnt=0, shift=0, timeout cnt=0, prefix pendings=0. Reset mid-frame discards the frame.
//  Edge detect: clk_prev registers ps2_clk_db; fall = clk_prev & ~ps2_clk_db. Data sampled
//   in the same cycle fall is seen.
//  FSM (advances only on fall unless timeout):
//   IDLE  : fall & data=0 -> DATA, bit_cnt=0. fall & data=1 -> stay IDLE, no error.
//   DATA  : shift in LSB first (shift <= {data, shift[7:1]}); after 8th bit -> PARITY.
//   PARITY: capture parity bit -> STOP.
//   STOP  : data=1 & (^shift ^ par)=1 -> accept; data=1 & parity bad -> parity_err;
//           data=0 -> frame_err (takes priority over parity). Always -> IDLE.
//  Latency: code/code_valid registered; strobe high in cycle after the stop-bit fall cycle.
//  Strobes are exactly 1 cycle; at most one of code_valid/parity_err/frame_err per frame.
//  Timeout: counter cleared on every fall and in IDLE; increments in other states.
//   count == TIMEOUT_CYCLES-1 with no fall that cycle -> frame_err, IDLE, counter clear.
//   Fall and timeout in same cycle: fall wins, no error.
//  busy = (state != IDLE), registered with state.
//  code holds its value between frames; unchanged on error frames.
// CONFIGURATION
//  PS2_BREAK_DECODE_EN defined:
//   accepted 8'hF0 -> set release pending; 8'hE0 -> set extended pending; neither strobes
//   code_valid nor updates code. Next accepted other byte: code_valid=1,
//   release_flag/extended_flag = pendings, then pendings clear same cycle.
//   parity_err or frame_err clears both pendings. Flags are 0 whenever code_valid=0.
//  Not defined: every accepted byte (incl. F0/E0) strobes code_valid; release_flag and
//   extended_flag tied 0; no pending registers.
// TESTING
//  T1 frame 0x1C (start0, bits 0,0,1,1,1,0,0,0, par0, stop1) -> code=8'h1C, 1-cycle
//     code_valid, no errors, busy high start..stop.
//  T2 frame 0x1C with par=1 -> parity_err 1 cycle, code_valid 0, code keeps prior value.
//  T3 frame 0x1C with stop=0 -> frame_err 1 cycle only (no parity_err), FSM back to IDLE.
//  T4 start + 3 bits then ps2_clk_db held high TIMEOUT_CYCLES (use 50 in bench) ->
//     frame_err, busy=0; next clean frame 0x5A -> code=8'h5A.
//  T5 rst_n low for 1 cycle after bit 4 of a frame -> all outputs 0 immediately, next
//     full frame 0x29 accepted normally.
//  T6 frames E0,F0,75: with PS2_BREAK_DECODE_EN -> single code_valid, code=8'h75,
//     release_flag=1, extended_flag=1; without -> 3 strobes (E0,F0,75), flags 0.

Source files
------------

// File: rtl/ps2_rx_ctrl.sv
// PS/2 receive frame sequencer: assembles 11-bit frames from the debounced keyboard clock/data.
// Optional break/extended prefix folding is enabled by defining PS2_BREAK_DECODE_EN.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | waiting for a start bit (falling edge, data=0)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | capturing the odd-parity bit
// S_STOP   | checking stop bit and parity, reporting result
module ps2_rx_ctrl #(
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int TO_W           = 17
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk_db,
   input  logic       ps2_data_db,
   output logic [7:0] code,
   output logic       code_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       busy,
   output logic       release_flag,
   output logic       extended_flag
);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   state_t            state_q, state_d;
   logic              clk_prev_q;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        shift_q, shift_d;
   logic              par_q, par_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [7:0]        code_q, code_d;
   logic              code_valid_q, code_valid_d;
   logic              parity_err_q, parity_err_d;
   logic              frame_err_q, frame_err_d;
   logic              busy_q, busy_d;
   logic              fall;
   logic              accept;

`ifdef PS2_BREAK_DECODE_EN
   logic rel_pend_q, rel_pend_d;
   logic ext_pend_q, ext_pend_d;
   logic release_flag_q, release_flag_d;
   logic extended_flag_q, extended_flag_d;
`endif

   assign fall = clk_prev_q & ~ps2_clk_db;

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      par_d        = par_q;
      to_cnt_d     = to_cnt_q;
      code_d       = code_q;
      code_valid_d = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      accept       = 1'b0;
`ifdef PS2_BREAK_DECODE_EN
      rel_pend_d      = rel_pend_q;
      ext_pend_d      = ext_pend_q;
      release_flag_d  = 1'b0;
      extended_flag_d = 1'b0;
`endif

      if (state_q == S_IDLE) begin
         to_cnt_d = '0;
         if (fall && !ps2_data_db) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
         end
      end else if (fall) begin
         to_cnt_d = '0;
         case (state_q)
            S_DATA: begin
               shift_d   = {ps2_data_db, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = S_PARITY;
            end
            S_PARITY: begin
               par_d   = ps2_data_db;
               state_d = S_STOP;
            end
            default: begin
               // A bad stop bit outranks a parity failure.
               if (!ps2_data_db)            frame_err_d  = 1'b1;
               else if (^shift_q ^ par_q)   accept       = 1'b1;
               else                         parity_err_d = 1'b1;
               state_d = S_IDLE;
            end
         endcase
      end else if (to_cnt_q == TO_LAST) begin
         frame_err_d = 1'b1;
         state_d     = S_IDLE;
         to_cnt_d    = '0;
      end else begin
         to_cnt_d = to_cnt_q + 1'b1;
      end

`ifdef PS2_BREAK_DECODE_EN
      if (accept) begin
         if (shift_q == 8'hF0) begin
            rel_pend_d = 1'b1;
         end else if (shift_q == 8'hE0) begin
            ext_pend_d = 1'b1;
         end else begin
            code_d          = shift_q;
            code_valid_d    = 1'b1;
            release_flag_d  = rel_pend_q;
            extended_flag_d = ext_pend_q;
            rel_pend_d      = 1'b0;
            ext_pend_d      = 1'b0;
         end
      end
      if (parity_err_d || frame_err_d) begin
         rel_pend_d = 1'b0;
         ext_pend_d = 1'b0;
      end
`else
      if (accept) begin
         code_d       = shift_q;
         code_valid_d = 1'b1;
      end
`endif

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         clk_prev_q   <= 1'b1;
         bit_cnt_q    <= 3'd0;
         shift_q      <= 8'h00;
         par_q        <= 1'b0;
         to_cnt_q     <= '0;
         code_q       <= 8'h00;
         code_valid_q <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         busy_q       <= 1'b0;
`ifdef PS2_BREAK_DECODE_EN
         rel_pend_q      <= 1'b0;
         ext_pend_q      <= 1'b0;
         release_flag_q  <= 1'b0;
         extended_flag_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         clk_prev_q   <= ps2_clk_db;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         par_q        <= par_d;
         to_cnt_q     <= to_cnt_d;
         code_q       <= code_d;
         code_valid_q <= code_valid_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         busy_q       <= busy_d;
`ifdef PS2_BREAK_DECODE_EN
         rel_pend_q      <= rel_pend_d;
         ext_pend_q      <= ext_pend_d;
         release_flag_q  <= release_flag_d;
         extended_flag_q <= extended_flag_d;
`endif
      end
   end

   assign code       = code_q;
   assign code_valid = code_valid_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign busy       = busy_q;
`ifdef PS2_BREAK_DECODE_EN
   assign release_flag  = release_flag_q;
   assign extended_flag = extended_flag_q;
`else
   assign release_flag  = 1'b0;
   assign extended_flag = 1'b0;
`endif

endmodule
